// File: rtl/riscv_writeback_if.sv
// Bundle of ALU, load-issue, memory-response and register-file write signals for riscv_writeback.
// Optional bypass signals exist only when RISCV_WB_BYPASS_EN is defined.
interface riscv_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        ld_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] w_data;
    logic [4:0]  w_addr;
    logic        w_enable;
    logic [31:0] busy;
`ifdef RISCV_WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_addr;
    logic [31:0] byp_data;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
        output mem_rvalid, mem_rdata,
        input  ld_ready, w_data, w_addr, w_enable, busy, byp_valid, byp_addr, byp_data
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
        input  mem_rvalid, mem_rdata,
        output ld_ready, w_data, w_addr, w_enable, busy, byp_valid, byp_addr, byp_data
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
        output mem_rvalid, mem_rdata,
        input  ld_ready, w_data, w_addr, w_enable, busy
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_funct3, ld_offset,
        input  mem_rvalid, mem_rdata,
        output ld_ready, w_data, w_addr, w_enable, busy
    );
`endif
endinterface

// File: rtl/riscv_writeback.sv
// RISC-V write-back stage: merges ALU results with in-order load responses onto the single
// register-file write port and publishes a busy scoreboard. RISCV_WB_BYPASS_EN adds bypass outputs.
module riscv_writeback #(
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    riscv_writeback_if.slave bus
);
    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(LQ_DEPTH);

    logic [4:0]          rd_r   [LQ_DEPTH];
    logic [2:0]          f3_r   [LQ_DEPTH];
    logic [1:0]          off_r  [LQ_DEPTH];
    logic [31:0]         data_r [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] has_data_r;
    logic [PW-1:0]       head_r;
    logic [PW-1:0]       tail_r;
    logic [PW-1:0]       resp_r;
    logic [PW:0]         count_r;
    logic [PW:0]         noresp_cnt_r;

    logic                w_enable_r;
    logic [4:0]          w_addr_r;
    logic [31:0]         w_data_r;

    logic                issue_s;
    logic                resp_acc_s;
    logic                alu_win_s;
    logic                retire_s;
    logic [31:0]         busy_s;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] raw);
        logic [31:0] w;
        w = raw >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h000000, w[7:0]};
            3'b101:  return {16'h0000, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Qualify issue/response and decide who owns the write port this cycle
    always_comb begin
        issue_s    = bus.ld_issue && (count_r < DEPTH_C);
        resp_acc_s = bus.mem_rvalid && (noresp_cnt_r != '0);
        alu_win_s  = bus.alu_valid && (bus.alu_rd != 5'd0);
        retire_s   = !alu_win_s && (count_r != '0) && has_data_r[head_r];
    end

    // Scoreboard: every live queue entry marks its rd; the in-flight write counts unless bypassed
    always_comb begin
        logic [PW-1:0] rel_s;
        logic          live_s;
        busy_s = 32'd0;
        rel_s  = '0;
        live_s = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            rel_s  = PW'(i) - head_r;
            live_s = ({1'b0, rel_s} < count_r);
            busy_s = busy_s | ({31'd0, live_s} << rd_r[i]);
        end
`ifndef RISCV_WB_BYPASS_EN
        busy_s = busy_s | ({31'd0, w_enable_r} << w_addr_r);
`endif
        busy_s[0] = 1'b0;
    end

    // Load queue: issue at tail, formatted response at resp, release at head
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_r       <= '0;
            tail_r       <= '0;
            resp_r       <= '0;
            count_r      <= '0;
            noresp_cnt_r <= '0;
            has_data_r   <= '0;
        end else begin
            if (issue_s) begin
                rd_r[tail_r]       <= bus.ld_rd;
                f3_r[tail_r]       <= bus.ld_funct3;
                off_r[tail_r]      <= bus.ld_offset;
                has_data_r[tail_r] <= 1'b0;
                tail_r             <= tail_r + PW'(1);
            end
            if (resp_acc_s) begin
                data_r[resp_r]     <= fmt_load(f3_r[resp_r], off_r[resp_r], bus.mem_rdata);
                has_data_r[resp_r] <= 1'b1;
                resp_r             <= resp_r + PW'(1);
            end
            if (retire_s) begin
                head_r <= head_r + PW'(1);
            end
            count_r      <= count_r + (PW+1)'(issue_s) - (PW+1)'(retire_s);
            noresp_cnt_r <= noresp_cnt_r + (PW+1)'(issue_s) - (PW+1)'(resp_acc_s);
        end
    end

    // Register-file write port: ALU has priority, otherwise retire a completed head load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_enable_r <= 1'b0;
            w_addr_r   <= 5'd0;
            w_data_r   <= 32'd0;
        end else if (alu_win_s) begin
            w_enable_r <= 1'b1;
            w_addr_r   <= bus.alu_rd;
            w_data_r   <= bus.alu_data;
        end else if (retire_s) begin
            w_enable_r <= (rd_r[head_r] != 5'd0);
            w_addr_r   <= rd_r[head_r];
            w_data_r   <= data_r[head_r];
        end else begin
            w_enable_r <= 1'b0;
        end
    end

    assign bus.w_enable = w_enable_r;
    assign bus.w_addr   = w_addr_r;
    assign bus.w_data   = w_data_r;
    assign bus.busy     = busy_s;
    assign bus.ld_ready = (count_r < DEPTH_C);
`ifdef RISCV_WB_BYPASS_EN
    assign bus.byp_valid = w_enable_r;
    assign bus.byp_addr  = w_addr_r;
    assign bus.byp_data  = w_data_r;
`endif
endmodule

// File: tb/tb_riscv_writeback.sv
// Directed self-checking bench for riscv_writeback (LQ_DEPTH=2); honours RISCV_WB_BYPASS_EN.
module tb_riscv_writeback;
`ifdef RISCV_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_writeback_if wb_if ();

    riscv_writeback #(.LQ_DEPTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (wb_if.slave)
    );

    always #5 clk = ~clk;

    logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  off_tab [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic [31:0] exp_tab [5] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_if.alu_valid  = 1'b0;
        wb_if.alu_rd     = 5'd0;
        wb_if.alu_data   = 32'd0;
        wb_if.ld_issue   = 1'b0;
        wb_if.ld_rd      = 5'd0;
        wb_if.ld_funct3  = 3'b000;
        wb_if.ld_offset  = 2'd0;
        wb_if.mem_rvalid = 1'b0;
        wb_if.mem_rdata  = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        wb_if.ld_issue  = 1'b1;
        wb_if.ld_rd     = rd;
        wb_if.ld_funct3 = f3;
        wb_if.ld_offset = off;
        step();
        wb_if.ld_issue  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        wb_if.mem_rvalid = 1'b1;
        wb_if.mem_rdata  = data;
        step();
        wb_if.mem_rvalid = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        check_val("rst_wen",   {31'd0, wb_if.w_enable}, 32'd0);
        check_val("rst_waddr", {27'd0, wb_if.w_addr},   32'd0);
        check_val("rst_wdata", wb_if.w_data,            32'd0);
        check_val("rst_busy",  wb_if.busy,              32'd0);
        check_val("rst_ready", {31'd0, wb_if.ld_ready}, 32'd1);
        rst = 1'b0;
        step();

        // ALU write, then ALU to x0
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 5'd5;
        wb_if.alu_data  = 32'hDEADBEEF;
        step();
        wb_if.alu_rd    = 5'd0;
        wb_if.alu_data  = 32'h12345678;
        check_val("alu_wen",   {31'd0, wb_if.w_enable}, 32'd1);
        check_val("alu_waddr", {27'd0, wb_if.w_addr},   32'd5);
        check_val("alu_wdata", wb_if.w_data,            32'hDEADBEEF);
        check_val("alu_busy",  wb_if.busy,              BYP ? 32'd0 : 32'h20);
`ifdef RISCV_WB_BYPASS_EN
        check_val("alu_byp_valid", {31'd0, wb_if.byp_valid}, 32'd1);
        check_val("alu_byp_data",  wb_if.byp_data,           32'hDEADBEEF);
`endif
        step();
        wb_if.alu_valid = 1'b0;
        check_val("alu_x0_wen", {31'd0, wb_if.w_enable}, 32'd0);

        // Load formatting
        for (int i = 0; i < 5; i++) begin
            issue(5'd9, f3_tab[i], off_tab[i]);
            check_val("fmt_busy_set", wb_if.busy, 32'h200);
            respond(32'h80FF7F01);
            check_val("fmt_lat_wen", {31'd0, wb_if.w_enable}, 32'd0);
            step();
            check_val("fmt_wen",   {31'd0, wb_if.w_enable}, 32'd1);
            check_val("fmt_waddr", {27'd0, wb_if.w_addr},   32'd9);
            check_val("fmt_wdata", wb_if.w_data,            exp_tab[i]);
            check_val("fmt_busy_wr", wb_if.busy, BYP ? 32'd0 : 32'h200);
            step();
            check_val("fmt_busy_clr", wb_if.busy, 32'd0);
        end

        // Response and ALU on the same cycle, ALU again next cycle
        issue(5'd3, 3'b010, 2'd0);
        wb_if.mem_rvalid = 1'b1;
        wb_if.mem_rdata  = 32'h11223344;
        wb_if.alu_valid  = 1'b1;
        wb_if.alu_rd     = 5'd4;
        wb_if.alu_data   = 32'hAAAA0004;
        step();
        wb_if.mem_rvalid = 1'b0;
        wb_if.alu_rd     = 5'd6;
        wb_if.alu_data   = 32'hBBBB0006;
        check_val("cf_alu1_addr", {27'd0, wb_if.w_addr}, 32'd4);
        check_val("cf_alu1_data", wb_if.w_data,          32'hAAAA0004);
        check_val("cf_busy3_a",   {31'd0, wb_if.busy[3]}, 32'd1);
        step();
        wb_if.alu_valid = 1'b0;
        check_val("cf_alu2_addr", {27'd0, wb_if.w_addr}, 32'd6);
        check_val("cf_busy3_b",   {31'd0, wb_if.busy[3]}, 32'd1);
        step();
        check_val("cf_ld_wen",  {31'd0, wb_if.w_enable}, 32'd1);
        check_val("cf_ld_addr", {27'd0, wb_if.w_addr},   32'd3);
        check_val("cf_ld_data", wb_if.w_data,            32'h11223344);
        check_val("cf_busy3_c", {31'd0, wb_if.busy[3]},  BYP ? 32'd0 : 32'd1);
        step();
        check_val("cf_busy3_d", {31'd0, wb_if.busy[3]},  32'd0);

        // Full queue
        issue(5'd1, 3'b010, 2'd0);
        issue(5'd2, 3'b010, 2'd0);
        check_val("full_ready0", {31'd0, wb_if.ld_ready}, 32'd0);
        issue(5'd8, 3'b010, 2'd0);
        check_val("full_busy", wb_if.busy, 32'h6);
        respond(32'h00001111);
        check_val("full_ready_ret", {31'd0, wb_if.ld_ready}, 32'd0);
        respond(32'h22220000);
        check_val("full_w1_addr", {27'd0, wb_if.w_addr},   32'd1);
        check_val("full_w1_data", wb_if.w_data,            32'h00001111);
        check_val("full_ready1",  {31'd0, wb_if.ld_ready}, 32'd1);
        step();
        check_val("full_w2_wen",  {31'd0, wb_if.w_enable}, 32'd1);
        check_val("full_w2_addr", {27'd0, wb_if.w_addr},   32'd2);
        check_val("full_w2_data", wb_if.w_data,            32'h22220000);
        step();
        check_val("full_busy_clr", wb_if.busy, 32'd0);
        respond(32'hDEAD0000);
        step();
        check_val("full_spurious_wen", {31'd0, wb_if.w_enable}, 32'd0);

        // Two loads to the same register
        issue(5'd7, 3'b010, 2'd0);
        issue(5'd7, 3'b010, 2'd0);
        check_val("same_busy", wb_if.busy, 32'h80);
        respond(32'h70000001);
        respond(32'h70000002);
        check_val("same_w1_data", wb_if.w_data, 32'h70000001);
        check_val("same_busy_1",  {31'd0, wb_if.busy[7]}, 32'd1);
        step();
        check_val("same_w2_data", wb_if.w_data, 32'h70000002);
        check_val("same_busy_2",  {31'd0, wb_if.busy[7]}, BYP ? 32'd0 : 32'd1);
        step();
        check_val("same_busy_3", wb_if.busy, 32'd0);

        // Reset with two loads pending
        issue(5'd10, 3'b010, 2'd0);
        issue(5'd11, 3'b010, 2'd0);
        check_val("rr_busy_pre", wb_if.busy, 32'h0C00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rr_busy",  wb_if.busy,              32'd0);
        check_val("rr_ready", {31'd0, wb_if.ld_ready}, 32'd1);
        respond(32'hCAFEF00D);
        step();
        check_val("rr_wen",   {31'd0, wb_if.w_enable}, 32'd0);
        check_val("rr_busy2", wb_if.busy,              32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
